// File: rtl/vga_pkg.sv
// Shared VGA image-ROM types: bus widths, arbiter state and read-owner tags.
package vga_pkg;

  localparam int ROM_ADDR_BUS_WIDTH = 17;
  localparam int PIX_WIDTH          = 24;
  // Wide enough for ROM_LATENCY+1 with ROM_LATENCY up to 4.
  localparam int DRAIN_W            = 3;

  typedef enum logic [1:0] {
    DISPLAY = 2'd0,
    SETTLE  = 2'd1,
    BG_OPEN = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_PIX = 1'b0,
    OWN_BG  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rom_tag_t;

endpackage

// File: rtl/rom_port_arbiter_tag_pipe.sv
// Fixed-depth shift pipeline carrying {valid, owner} alongside each ROM read.
module rom_tag_pipe
  import vga_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic     i_clk,
  input  logic     i_srst,
  input  rom_tag_t i_tag,
  output rom_tag_t o_tag
);

  rom_tag_t r_stage [DEPTH];
  rom_tag_t w_stage_in [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_link
    if (gi == 0) begin : g_head
      assign w_stage_in[gi] = i_tag;
    end else begin : g_body
      assign w_stage_in[gi] = r_stage[gi-1];
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (i_srst) begin
        r_stage[i] <= '0;
      end else begin
        r_stage[i] <= w_stage_in[i];
      end
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one image-ROM read port between the display scan-out and a background
// engine; background reads are only admitted during blanking once the pipe drains.
module rom_port_arbiter #(
  parameter int ROM_ADDR_BUS_WIDTH = vga_pkg::ROM_ADDR_BUS_WIDTH,
  parameter int PIX_WIDTH          = vga_pkg::PIX_WIDTH,
  parameter int ROM_LATENCY        = 2,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          VGA_CLK,
  input  logic                          RESET,
  input  logic                          VGA_BLANK_N,
  input  logic                          PIX_REQ,
  input  logic [ROM_ADDR_BUS_WIDTH-1:0] PIX_ADDR,
  input  logic                          BG_REQ,
  input  logic [ROM_ADDR_BUS_WIDTH-1:0] BG_ADDR,
  output logic                          BG_GNT,
  output logic [ROM_ADDR_BUS_WIDTH-1:0] ROM_ADDR,
  input  logic [PIX_WIDTH-1:0]          ROM_Q,
  output logic [PIX_WIDTH-1:0]          PIX_DATA,
  output logic                          PIX_VALID,
  output logic [PIX_WIDTH-1:0]          BG_DATA,
  output logic                          BG_VALID,
  output logic [CNT_WIDTH-1:0]          CONFLICT_CNT
);

  import vga_pkg::*;

  localparam int                 TAG_DEPTH  = ROM_LATENCY + 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(ROM_LATENCY + 1);

  arb_state_e                    r_state;
  arb_state_e                    w_state_next;
  logic [DRAIN_W-1:0]            r_drain;
  logic [DRAIN_W-1:0]            w_drain_next;
  logic [ROM_ADDR_BUS_WIDTH-1:0] r_rom_addr;
  logic [PIX_WIDTH-1:0]          r_pix_data;
  logic [PIX_WIDTH-1:0]          r_bg_data;
  logic                          r_pix_valid;
  logic                          r_bg_valid;
  logic [CNT_WIDTH-1:0]          r_conflict_cnt;
  logic                          w_bg_gnt;
  logic                          w_conflict;
  rom_tag_t                      w_tag_in;
  rom_tag_t                      w_tag_out;

  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      r_state <= DISPLAY;
      r_drain <= '0;
    end else begin
      r_state <= w_state_next;
      r_drain <= w_drain_next;
    end
  end

  // Blanking opens the port only after every display read already issued has emerged.
  always_comb begin
    w_state_next = r_state;
    w_drain_next = r_drain;
    if (VGA_BLANK_N) begin
      w_state_next = DISPLAY;
      w_drain_next = '0;
    end else begin
      case (r_state)
        DISPLAY: begin
          w_state_next = SETTLE;
          w_drain_next = DRAIN_LOAD;
        end
        SETTLE: begin
          if (r_drain <= DRAIN_W'(1)) begin
            w_state_next = BG_OPEN;
            w_drain_next = '0;
          end else begin
            w_drain_next = r_drain - 1'b1;
          end
        end
        BG_OPEN: w_state_next = BG_OPEN;
        default: begin
          w_state_next = DISPLAY;
          w_drain_next = '0;
        end
      endcase
    end
  end

  assign w_bg_gnt   = (r_state == BG_OPEN) && BG_REQ && !PIX_REQ && !RESET;
  assign w_conflict = (r_state == BG_OPEN) && BG_REQ && PIX_REQ;

  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      r_rom_addr <= '0;
    end else if (PIX_REQ) begin
      r_rom_addr <= PIX_ADDR;
    end else if (w_bg_gnt) begin
      r_rom_addr <= BG_ADDR;
    end
  end

  assign w_tag_in.valid = !RESET && (PIX_REQ || w_bg_gnt);
  assign w_tag_in.owner = PIX_REQ ? OWN_PIX : OWN_BG;

  rom_tag_pipe #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_pipe (
    .i_clk  (VGA_CLK),
    .i_srst (RESET),
    .i_tag  (w_tag_in),
    .o_tag  (w_tag_out)
  );

  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      r_pix_data  <= '0;
      r_bg_data   <= '0;
      r_pix_valid <= 1'b0;
      r_bg_valid  <= 1'b0;
    end else begin
      r_pix_valid <= w_tag_out.valid && (w_tag_out.owner == OWN_PIX);
      r_bg_valid  <= w_tag_out.valid && (w_tag_out.owner == OWN_BG);
      if (w_tag_out.valid && (w_tag_out.owner == OWN_PIX)) begin
        r_pix_data <= ROM_Q;
      end
      if (w_tag_out.valid && (w_tag_out.owner == OWN_BG)) begin
        r_bg_data <= ROM_Q;
      end
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != '1)) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign BG_GNT       = w_bg_gnt;
  assign ROM_ADDR     = r_rom_addr;
  assign PIX_DATA     = r_pix_data;
  assign PIX_VALID    = r_pix_valid;
  assign BG_DATA      = r_bg_data;
  assign BG_VALID     = r_bg_valid;
  assign CONFLICT_CNT = r_conflict_cnt;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a two-cycle ROM returning its address.
module tb_rom_port_arbiter;

  localparam int AW = 17;
  localparam int PW = 24;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          blank_n;
  logic          pix_req;
  logic [AW-1:0] pix_addr;
  logic          bg_req;
  logic [AW-1:0] bg_addr;
  logic          bg_gnt;
  logic [AW-1:0] rom_addr;
  logic [PW-1:0] rom_q;
  logic [PW-1:0] pix_data;
  logic          pix_valid;
  logic [PW-1:0] bg_data;
  logic          bg_valid;
  logic [CW-1:0] conflict_cnt;

  logic [AW-1:0] rom_q1 = '0;
  logic [AW-1:0] rom_q2 = '0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_q1 <= rom_addr;
    rom_q2 <= rom_q1;
  end
  assign rom_q = {{(PW-AW){1'b0}}, rom_q2};

  rom_port_arbiter #(
    .ROM_ADDR_BUS_WIDTH (AW),
    .PIX_WIDTH          (PW),
    .ROM_LATENCY        (2),
    .CNT_WIDTH          (CW)
  ) dut (
    .VGA_CLK      (clk),
    .RESET        (rst),
    .VGA_BLANK_N  (blank_n),
    .PIX_REQ      (pix_req),
    .PIX_ADDR     (pix_addr),
    .BG_REQ       (bg_req),
    .BG_ADDR      (bg_addr),
    .BG_GNT       (bg_gnt),
    .ROM_ADDR     (rom_addr),
    .ROM_Q        (rom_q),
    .PIX_DATA     (pix_data),
    .PIX_VALID    (pix_valid),
    .BG_DATA      (bg_data),
    .BG_VALID     (bg_valid),
    .CONFLICT_CNT (conflict_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pv_cnt;
    int bv_cnt;

    rst = 1'b1; blank_n = 1'b1; pix_req = 1'b0; bg_req = 1'b1;
    pix_addr = '0; bg_addr = '0;
    tick; tick; tick;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_bg_valid", bg_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_bg_data", bg_data, 0);
    chk("rst_conflict", conflict_cnt, 0);
    chk("rst_bg_gnt", bg_gnt, 0);
    rst = 1'b0; bg_req = 1'b0;
    tick;

    // Display read, latency 4
    bg_req = 1'b1; pix_req = 1'b1; pix_addr = 17'h00010;
    #1 chk("disp_bg_gnt", bg_gnt, 0);
    tick;
    pix_req = 1'b0;
    chk("pix_rom_addr", rom_addr, 17'h00010);
    chk("pix_lat_c1", pix_valid, 0);
    tick; chk("pix_lat_c2", pix_valid, 0);
    tick; chk("pix_lat_c3", pix_valid, 0);
    tick;
    chk("pix_valid_c4", pix_valid, 1);
    chk("pix_data_c4", pix_data, 24'h000010);
    chk("pix_bgv_c4", bg_valid, 0);
    tick;
    chk("pix_valid_c5", pix_valid, 0);
    chk("pix_data_hold", pix_data, 24'h000010);
    bg_req = 1'b0;

    // Blank falls: grant opens at cycle 4
    blank_n = 1'b0; bg_req = 1'b1; bg_addr = 17'h00123;
    #1 chk("settle_gnt_c0", bg_gnt, 0);
    tick; chk("settle_gnt_c1", bg_gnt, 0);
    tick; chk("settle_gnt_c2", bg_gnt, 0);
    tick; chk("settle_gnt_c3", bg_gnt, 0);
    tick; chk("open_gnt_c4", bg_gnt, 1);
    tick;
    chk("bg_rom_addr_c5", rom_addr, 17'h00123);
    bg_addr = 17'h00124;
    #1 chk("open_gnt_c5", bg_gnt, 1);
    tick;
    bg_req = 1'b0;
    chk("bg_rom_addr_c6", rom_addr, 17'h00124);
    tick; chk("bg_valid_c7", bg_valid, 0);
    tick;
    chk("bg_valid_c8", bg_valid, 1);
    chk("bg_data_c8", bg_data, 24'h000123);
    chk("bg_pixv_c8", pix_valid, 0);
    tick;
    chk("bg_valid_c9", bg_valid, 1);
    chk("bg_data_c9", bg_data, 24'h000124);
    tick;
    chk("bg_valid_c10", bg_valid, 0);
    chk("bg_data_hold", bg_data, 24'h000124);

    // Conflicts in BG_OPEN: display keeps the port
    pv_cnt = 0; bv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 5) begin
        pix_req = 1'b1; bg_req = 1'b1; pix_addr = 17'h00200 + 17'(i);
      end else begin
        pix_req = 1'b0; bg_req = 1'b0;
      end
      #1;
      if (i < 5) chk("conflict_gnt", bg_gnt, 0);
      if (pix_valid) pv_cnt++;
      if (bg_valid) bv_cnt++;
      tick;
    end
    chk("conflict_pix_pulses", pv_cnt, 5);
    chk("conflict_bg_pulses", bv_cnt, 0);
    chk("conflict_last_data", pix_data, 24'h000204);
    chk("conflict_cnt_5", conflict_cnt, 5);

    // BG grant at top of range, then blank rises mid-flight
    bg_req = 1'b1; bg_addr = 17'h1FFFF; pix_req = 1'b0;
    #1 chk("edge_gnt_g", bg_gnt, 1);
    tick;
    blank_n = 1'b1; bg_req = 1'b0;
    chk("edge_rom_addr", rom_addr, 17'h1FFFF);
    tick;
    bg_req = 1'b1;
    for (int j = 2; j <= 6; j++) begin
      #1 chk("edge_no_gnt", bg_gnt, 0);
      if (j == 4) begin
        chk("edge_bg_valid", bg_valid, 1);
        chk("edge_bg_data", bg_data, 24'h01FFFF);
      end else begin
        chk("edge_bg_idle", bg_valid, 0);
      end
      tick;
    end
    bg_req = 1'b0;

    // Reads in flight and during reset are discarded
    pix_req = 1'b1; pix_addr = 17'h00030;
    tick;
    pix_addr = 17'h00031;
    tick;
    rst = 1'b1; pix_addr = 17'h00032;
    tick;
    rst = 1'b0; pix_req = 1'b0;
    pv_cnt = 0; bv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (pix_valid) pv_cnt++;
      if (bg_valid) bv_cnt++;
      tick;
    end
    chk("rstfl_pix_pulses", pv_cnt, 0);
    chk("rstfl_bg_pulses", bv_cnt, 0);
    chk("rstfl_rom_addr", rom_addr, 0);
    chk("rstfl_pix_data", pix_data, 0);
    chk("rstfl_bg_data", bg_data, 0);
    chk("rstfl_conflict", conflict_cnt, 0);

    // Saturation of the conflict counter
    blank_n = 1'b0;
    tick; tick; tick; tick;
    pix_req = 1'b1; bg_req = 1'b1; pix_addr = 17'h00040;
    repeat (65535) tick;
    chk("sat_reach", conflict_cnt, 16'hFFFF);
    tick;
    chk("sat_hold", conflict_cnt, 16'hFFFF);
    pix_req = 1'b0; bg_req = 1'b0;
    tick;
    chk("sat_idle", conflict_cnt, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
